// File: rtl/core_pkg.sv
// Shared definitions for the core's hazard/sequencing logic: controller state
// encoding, forwarding-select codes, register-index width and the common
// destination/source match rule.
package core_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // A producer matches a consumer only if it writes back, targets a nonzero
  // register, and that register is a source the consumer actually reads.
  function automatic logic rd_match(input logic                 wb_en,
                                    input logic [REG_IDX_W-1:0] rd,
                                    input logic                 used,
                                    input logic [REG_IDX_W-1:0] rs);
    return wb_en && (rd != '0) && used && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline and the hazard controller: decode sources,
// EX/MEM/WB destination fields, redirect/LSU/ebreak events in, and the
// stall/flush/forwarding controls out.
interface hazard_ctrl_if;

  logic [core_pkg::REG_IDX_W-1:0] id_index_rs1;
  logic [core_pkg::REG_IDX_W-1:0] id_index_rs2;
  logic                           id_rs1_used;
  logic                           id_rs2_used;
  logic [core_pkg::REG_IDX_W-1:0] ex_index_rd;
  logic                           ex_wb_en;
  logic                           ex_load_en;
  logic [core_pkg::REG_IDX_W-1:0] mem_index_rd;
  logic                           mem_wb_en;
  logic                           mem_load_en;
  logic [core_pkg::REG_IDX_W-1:0] wb_index_rd;
  logic                           wb_wb_en;
  logic                           ex_redirect;
  logic                           lsu_req;
  logic                           lsu_ready;
  logic                           ex_ebreak;

  logic                           pc_stall;
  logic                           ifid_stall;
  logic                           ifid_flush;
  logic                           ld_hz_nop;
  logic                           flush_nop;
  logic                           pipe_stall;
  logic [1:0]                     fwd_sel_rs1;
  logic [1:0]                     fwd_sel_rs2;
  logic                           halted;

  // Pipeline side: supplies stage fields and events, consumes controls.
  modport master (
    output id_index_rs1, id_index_rs2, id_rs1_used, id_rs2_used,
    output ex_index_rd, ex_wb_en, ex_load_en,
    output mem_index_rd, mem_wb_en, mem_load_en,
    output wb_index_rd, wb_wb_en,
    output ex_redirect, lsu_req, lsu_ready, ex_ebreak,
    input  pc_stall, ifid_stall, ifid_flush, ld_hz_nop, flush_nop,
    input  pipe_stall, fwd_sel_rs1, fwd_sel_rs2, halted
  );

  // Controller side.
  modport slave (
    input  id_index_rs1, id_index_rs2, id_rs1_used, id_rs2_used,
    input  ex_index_rd, ex_wb_en, ex_load_en,
    input  mem_index_rd, mem_wb_en, mem_load_en,
    input  wb_index_rd, wb_wb_en,
    input  ex_redirect, lsu_req, lsu_ready, ex_ebreak,
    output pc_stall, ifid_stall, ifid_flush, ld_hz_nop, flush_nop,
    output pipe_stall, fwd_sel_rs1, fwd_sel_rs2, halted
  );

endinterface

// File: rtl/hz_fwd_match.sv
// Per-source comparator: reports which of EX/MEM/WB hold a matching producer
// (hit_o = {wb, mem, ex}) and the youngest-first forwarding select. A load
// still in EX has no data yet, so it blocks forwarding rather than falling
// through to an older, stale producer.
module hz_fwd_match
  import core_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic                 rs_used_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_wb_en_i,
  input  logic                 ex_load_en_i,
  input  logic [REG_IDX_W-1:0] mem_rd_i,
  input  logic                 mem_wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 wb_wb_en_i,
  output logic [2:0]           hit_o,
  output logic [1:0]           sel_o
);

  assign hit_o[0] = rd_match(ex_wb_en_i,  ex_rd_i,  rs_used_i, rs_i);
  assign hit_o[1] = rd_match(mem_wb_en_i, mem_rd_i, rs_used_i, rs_i);
  assign hit_o[2] = rd_match(wb_wb_en_i,  wb_rd_i,  rs_used_i, rs_i);

  // Youngest matching stage wins the forwarding mux.
  always_comb begin
    sel_o = FWD_RF;
    if (hit_o[0])      sel_o = ex_load_en_i ? FWD_RF : FWD_EX;
    else if (hit_o[1]) sel_o = FWD_MEM;
    else if (hit_o[2]) sel_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core. Resolves halt,
// memory wait, branch-redirect flush and data-hazard stalls in that priority
// order, and drives operand forwarding selects.
// Build option: define HAZARD_FWD_EN to enable forwarding; then only a
// load-use against EX stalls. Without it, fwd selects are 0 and any pending
// producer in EX/MEM/WB stalls decode.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          rstn,
  hazard_ctrl_if.slave hz
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [2:0] hit_rs1, hit_rs2;
  logic [1:0] sel_rs1, sel_rs2;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       data_hz;
  logic       lsu_wait;

  logic       pc_stall_c, ifid_stall_c, ifid_flush_c, ld_hz_nop_c;
  logic       flush_nop_c, pipe_stall_c, halted_c;
  logic [1:0] fwd_sel_rs1_c, fwd_sel_rs2_c;

  hz_fwd_match u_match_rs1 (
    .rs_i         (hz.id_index_rs1),
    .rs_used_i    (hz.id_rs1_used),
    .ex_rd_i      (hz.ex_index_rd),
    .ex_wb_en_i   (hz.ex_wb_en),
    .ex_load_en_i (hz.ex_load_en),
    .mem_rd_i     (hz.mem_index_rd),
    .mem_wb_en_i  (hz.mem_wb_en),
    .wb_rd_i      (hz.wb_index_rd),
    .wb_wb_en_i   (hz.wb_wb_en),
    .hit_o        (hit_rs1),
    .sel_o        (sel_rs1)
  );

  hz_fwd_match u_match_rs2 (
    .rs_i         (hz.id_index_rs2),
    .rs_used_i    (hz.id_rs2_used),
    .ex_rd_i      (hz.ex_index_rd),
    .ex_wb_en_i   (hz.ex_wb_en),
    .ex_load_en_i (hz.ex_load_en),
    .mem_rd_i     (hz.mem_index_rd),
    .mem_wb_en_i  (hz.mem_wb_en),
    .wb_rd_i      (hz.wb_index_rd),
    .wb_wb_en_i   (hz.wb_wb_en),
    .hit_o        (hit_rs2),
    .sel_o        (sel_rs2)
  );

`ifdef HAZARD_FWD_EN
  // With forwarding only a load still in EX cannot be bypassed.
  assign data_hz = hz.ex_load_en & (hit_rs1[0] | hit_rs2[0]);
  assign fwd_rs1 = sel_rs1;
  assign fwd_rs2 = sel_rs2;
  logic [3:0] unused_hit;
  assign unused_hit = {hit_rs1[2:1], hit_rs2[2:1]};
`else
  // Without forwarding decode waits until the producer has left WB.
  assign data_hz = (|hit_rs1) | (|hit_rs2);
  assign fwd_rs1 = FWD_RF;
  assign fwd_rs2 = FWD_RF;
  logic [3:0] unused_sel;
  assign unused_sel = {sel_rs1, sel_rs2};
`endif

  // MEM-stage loads forward like any other MEM producer.
  logic unused_mem_load;
  assign unused_mem_load = hz.mem_load_en;

  assign lsu_wait = hz.lsu_req & ~hz.lsu_ready;

  // State and flush counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and output decode, highest priority first.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    ld_hz_nop_c   = 1'b0;
    flush_nop_c   = 1'b0;
    pipe_stall_c  = 1'b0;
    halted_c      = 1'b0;
    fwd_sel_rs1_c = fwd_rs1;
    fwd_sel_rs2_c = fwd_rs2;

    case (state_q)
      ST_RUN: begin
        if (hz.ex_ebreak) begin
          state_d       = ST_HALT;
          pipe_stall_c  = 1'b1;
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          halted_c      = 1'b1;
          fwd_sel_rs1_c = FWD_RF;
          fwd_sel_rs2_c = FWD_RF;
        end else if (lsu_wait) begin
          state_d      = ST_MEMWAIT;
          pipe_stall_c = 1'b1;
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
        end else if (hz.ex_redirect) begin
          flush_nop_c  = 1'b1;
          ifid_flush_c = 1'b1;
          cnt_d        = FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) state_d = ST_FLUSH;
        end else if (data_hz) begin
          ld_hz_nop_c  = 1'b1;
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
        end
      end

      // EX holds a bubble here, so ebreak and redirect are not acted on.
      ST_FLUSH: begin
        flush_nop_c  = 1'b1;
        ifid_flush_c = 1'b1;
        if (lsu_wait) begin
          pipe_stall_c = 1'b1;
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end

      ST_MEMWAIT: begin
        if (hz.lsu_ready) begin
          state_d = ST_RUN;
        end else begin
          pipe_stall_c = 1'b1;
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
        end
      end

      ST_HALT: begin
        pipe_stall_c  = 1'b1;
        pc_stall_c    = 1'b1;
        ifid_stall_c  = 1'b1;
        halted_c      = 1'b1;
        fwd_sel_rs1_c = FWD_RF;
        fwd_sel_rs2_c = FWD_RF;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // Outputs read as idle for as long as reset is held, whatever the inputs.
    if (!rstn) begin
      pc_stall_c    = 1'b0;
      ifid_stall_c  = 1'b0;
      ifid_flush_c  = 1'b0;
      ld_hz_nop_c   = 1'b0;
      flush_nop_c   = 1'b0;
      pipe_stall_c  = 1'b0;
      halted_c      = 1'b0;
      fwd_sel_rs1_c = FWD_RF;
      fwd_sel_rs2_c = FWD_RF;
    end
  end

  assign hz.pc_stall    = pc_stall_c;
  assign hz.ifid_stall  = ifid_stall_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.ld_hz_nop   = ld_hz_nop_c;
  assign hz.flush_nop   = flush_nop_c;
  assign hz.pipe_stall  = pipe_stall_c;
  assign hz.fwd_sel_rs1 = fwd_sel_rs1_c;
  assign hz.fwd_sel_rs2 = fwd_sel_rs2_c;
  assign hz.halted      = halted_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (FLUSH_CYCLES = 2). Expected output vectors are
// queued as each cycle's stimulus is driven and compared on the falling edge.
// Expectations follow the HAZARD_FWD_EN setting of the build.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  hazard_ctrl_if hzif ();

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hzif.slave)
  );

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Output vector: {pc_stall, ifid_stall, ifid_flush, ld_hz_nop, flush_nop,
  //                 pipe_stall, fwd_sel_rs1[1:0], fwd_sel_rs2[1:0], halted}
  localparam logic [10:0] M_PC  = 11'h400;
  localparam logic [10:0] M_IS  = 11'h200;
  localparam logic [10:0] M_IF  = 11'h100;
  localparam logic [10:0] M_LH  = 11'h080;
  localparam logic [10:0] M_FN  = 11'h040;
  localparam logic [10:0] M_PS  = 11'h020;
  localparam logic [10:0] M_HLT = 11'h001;
  localparam logic [10:0] HZ    = M_PC | M_IS | M_LH;
  localparam logic [10:0] FL    = M_IF | M_FN;
  localparam logic [10:0] MW    = M_PS | M_PC | M_IS;
  localparam logic [10:0] HALTV = M_PS | M_PC | M_IS | M_HLT;

  // ctl = {redirect, lsu_req, lsu_ready, ebreak}
  localparam logic [3:0] C_RED = 4'b1000;
  localparam logic [3:0] C_REQ = 4'b0100;
  localparam logic [3:0] C_RDY = 4'b0010;
  localparam logic [3:0] C_EBK = 4'b0001;
  localparam logic [6:0] NP    = 7'd0;
  localparam logic [5:0] NS    = 6'd0;

  typedef struct packed {
    logic [6:0]  ex;   // {wb_en, load_en, rd}
    logic [6:0]  mem;  // {wb_en, load_en, rd}
    logic [5:0]  wb;   // {wb_en, rd}
    logic [5:0]  rs1;  // {used, idx}
    logic [5:0]  rs2;  // {used, idx}
    logic [3:0]  ctl;
    logic [10:0] exp;
  } step_t;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];

  function automatic logic [6:0] prod(input logic ld, input logic [4:0] rd);
    return {1'b1, ld, rd};
  endfunction

  function automatic logic [5:0] src(input logic [4:0] rs);
    return {1'b1, rs};
  endfunction

  function automatic logic [10:0] f1(input logic [1:0] v);
    return {6'd0, v, 3'd0};
  endfunction

  function automatic logic [10:0] f2(input logic [1:0] v);
    return {8'd0, v, 1'b0};
  endfunction

  function automatic step_t mk(input logic [6:0] ex, input logic [6:0] mem,
                               input logic [5:0] wb, input logic [5:0] rs1,
                               input logic [5:0] rs2, input logic [3:0] ctl,
                               input logic [10:0] exp);
    step_t s;
    s.ex = ex; s.mem = mem; s.wb = wb; s.rs1 = rs1; s.rs2 = rs2;
    s.ctl = ctl; s.exp = exp;
    return s;
  endfunction

  function automatic logic [10:0] outs();
    return {hzif.pc_stall, hzif.ifid_stall, hzif.ifid_flush, hzif.ld_hz_nop,
            hzif.flush_nop, hzif.pipe_stall, hzif.fwd_sel_rs1,
            hzif.fwd_sel_rs2, hzif.halted};
  endfunction

  task automatic apply(input step_t s);
    hzif.ex_wb_en     = s.ex[6];
    hzif.ex_load_en   = s.ex[5];
    hzif.ex_index_rd  = s.ex[4:0];
    hzif.mem_wb_en    = s.mem[6];
    hzif.mem_load_en  = s.mem[5];
    hzif.mem_index_rd = s.mem[4:0];
    hzif.wb_wb_en     = s.wb[5];
    hzif.wb_index_rd  = s.wb[4:0];
    hzif.id_rs1_used  = s.rs1[5];
    hzif.id_index_rs1 = s.rs1[4:0];
    hzif.id_rs2_used  = s.rs2[5];
    hzif.id_index_rs2 = s.rs2[4:0];
    {hzif.ex_redirect, hzif.lsu_req, hzif.lsu_ready, hzif.ex_ebreak} = s.ctl;
  endtask

  task automatic test_reset();
    logic [10:0] g;
    rstn = 1'b0;
    apply(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    g = outs(); checks++;
    if (g !== 11'd0) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", g, 11'd0);
    end
    // Events held during reset must not leak to the outputs.
    apply(mk(prod(1'b1, 5'd2), NP, NS, src(5'd2), NS, C_REQ | C_EBK, 11'd0));
    @(negedge clk);
    g = outs(); checks++;
    if (g !== 11'd0) begin
      errors++; $display("FAIL reset_events: got %b expected %b", g, 11'd0);
    end
    @(posedge clk); #1;
    apply(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    rstn = 1'b1;
    @(negedge clk);
    g = outs(); checks++;
    if (g !== 11'd0) begin
      errors++; $display("FAIL reset_release: got %b expected %b", g, 11'd0);
    end
  endtask

  task automatic test_fwd_priority();
    step_t st[$];
    logic [10:0] e, g;
    st.push_back(mk(prod(1'b0, 5'd7), prod(1'b0, 5'd7), {1'b1, 5'd7}, NS, src(5'd7), 4'd0,
                    FWD ? f2(FWD_EX) : HZ));
    st.push_back(mk(prod(1'b0, 5'd0), prod(1'b0, 5'd0), {1'b1, 5'd0}, NS, src(5'd0), 4'd0, 11'd0));
    st.push_back(mk(prod(1'b0, 5'd7), prod(1'b0, 5'd7), {1'b1, 5'd7}, NS, {1'b0, 5'd7}, 4'd0, 11'd0));
    st.push_back(mk(NP, prod(1'b0, 5'd7), {1'b1, 5'd7}, src(5'd7), src(5'd7), 4'd0,
                    FWD ? (f1(FWD_MEM) | f2(FWD_MEM)) : HZ));
    st.push_back(mk({2'b00, 5'd7}, NP, {1'b1, 5'd7}, src(5'd7), NS, 4'd0,
                    FWD ? f1(FWD_WB) : HZ));
    st.push_back(mk(prod(1'b0, 5'd9), prod(1'b0, 5'd8), {1'b1, 5'd6}, src(5'd6), src(5'd8), 4'd0,
                    FWD ? (f1(FWD_WB) | f2(FWD_MEM)) : HZ));
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]); sb.push_back(st[i].exp);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL fwd_priority step %0d: got %b expected %b", i, g, e);
      end
    end
  endtask

  task automatic test_load_use();
    step_t st[$];
    logic [10:0] e, g;
    st.push_back(mk(prod(1'b1, 5'd5), NP, NS, src(5'd5), NS, 4'd0, HZ));
    st.push_back(mk(NP, prod(1'b1, 5'd5), NS, src(5'd5), NS, 4'd0, FWD ? f1(FWD_MEM) : HZ));
    st.push_back(mk(NP, NP, {1'b1, 5'd5}, src(5'd5), NS, 4'd0, FWD ? f1(FWD_WB) : HZ));
    st.push_back(mk(NP, NP, NS, src(5'd5), NS, 4'd0, 11'd0));
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]); sb.push_back(st[i].exp);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL load_use step %0d: got %b expected %b", i, g, e);
      end
    end
  endtask

  task automatic test_alu_dep();
    step_t st[$];
    logic [10:0] e, g;
    st.push_back(mk(prod(1'b0, 5'd3), NP, NS, src(5'd3), NS, 4'd0, FWD ? f1(FWD_EX) : HZ));
    st.push_back(mk(NP, prod(1'b0, 5'd3), NS, src(5'd3), NS, 4'd0, FWD ? f1(FWD_MEM) : HZ));
    st.push_back(mk(NP, NP, {1'b1, 5'd3}, src(5'd3), NS, 4'd0, FWD ? f1(FWD_WB) : HZ));
    st.push_back(mk(NP, NP, NS, src(5'd3), NS, 4'd0, 11'd0));
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]); sb.push_back(st[i].exp);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL alu_dep step %0d: got %b expected %b", i, g, e);
      end
    end
  endtask

  task automatic test_redirect();
    step_t st[$];
    logic [10:0] e, g;
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, C_RED, FL));
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, 4'd0, FL));
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, 4'd0, HZ));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, C_RED, FL));
    st.push_back(mk(NP, NP, NS, NS, NS, C_EBK, FL));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]); sb.push_back(st[i].exp);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL redirect step %0d: got %b expected %b", i, g, e);
      end
    end
  endtask

  task automatic test_memwait();
    step_t st[$];
    logic [10:0] e, g;
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, C_REQ, MW));
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, C_REQ | C_RED, MW));
    st.push_back(mk(prod(1'b1, 5'd4), NP, NS, src(5'd4), NS, C_REQ, MW));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ | C_RDY, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ | C_RDY, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    st.push_back(mk(NP, NP, NS, NS, NS, C_RED, FL));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ, FL | MW));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ, FL | MW));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ, FL | MW));
    st.push_back(mk(NP, NP, NS, NS, NS, C_REQ | C_RDY, FL));
    st.push_back(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]); sb.push_back(st[i].exp);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL memwait step %0d: got %b expected %b", i, g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t st[$];
    logic [10:0] e, g;
    // Reset in the middle of FLUSH, then in the middle of MEMWAIT.
    for (int k = 0; k < 2; k++) begin
      st.delete();
      if (k == 0) begin
        st.push_back(mk(NP, NP, NS, NS, NS, C_RED, FL));
      end else begin
        st.push_back(mk(NP, NP, NS, NS, NS, C_REQ, MW));
        st.push_back(mk(NP, NP, NS, NS, NS, C_REQ, MW));
      end
      foreach (st[i]) begin
        @(posedge clk); #1;
        apply(st[i]); sb.push_back(st[i].exp);
        @(negedge clk);
        e = sb.pop_front(); g = outs(); checks++;
        if (g !== e) begin
          errors++; $display("FAIL async_reset_pre%0d step %0d: got %b expected %b", k, i, g, e);
        end
      end
      @(posedge clk); #2;
      rstn = 1'b0;
      sb.push_back(11'd0);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL async_reset_held%0d: got %b expected %b", k, g, e);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      apply(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
      sb.push_back(11'd0);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL async_reset_after%0d: got %b expected %b", k, g, e);
      end
    end
  endtask

  task automatic test_halt();
    logic [10:0] e, g;
    logic [3:0]  ctl;
    @(posedge clk); #1;
    apply(mk(NP, NP, NS, NS, NS, C_EBK, 11'd0));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      ctl = (i % 3 == 0) ? C_RED : ((i % 3 == 1) ? C_REQ : 4'd0);
      apply(mk(prod(1'b0, 5'd6), prod(1'b0, 5'd6), NS, src(5'd6), src(5'd6), ctl, HALTV));
      sb.push_back(HALTV);
      @(negedge clk);
      e = sb.pop_front(); g = outs(); checks++;
      if (g !== e) begin
        errors++; $display("FAIL halt cycle %0d: got %b expected %b", i, g, e);
      end
    end
    @(posedge clk); #1;
    apply(mk(NP, NP, NS, NS, NS, 4'd0, 11'd0));
    #2 rstn = 1'b0;
    sb.push_back(11'd0);
    @(negedge clk);
    e = sb.pop_front(); g = outs(); checks++;
    if (g !== e) begin
      errors++; $display("FAIL halt_async_reset: got %b expected %b", g, e);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    sb.push_back(11'd0);
    @(negedge clk);
    e = sb.pop_front(); g = outs(); checks++;
    if (g !== e) begin
      errors++; $display("FAIL halt_after_reset: got %b expected %b", g, e);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_alu_dep();
    test_redirect();
    test_memwait();
    test_async_reset();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
